id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline.
- Sits between fetch (consumes the 64-bit IF/ID word) and execute (produces every execute-stage input).
- Contains the register file with write-back bypass, main control decode, sign extension, load-use hazard detection (stall) and the ID/EX pipeline register with bubble insertion on stall or flush.

Parameters:
- NUM_REGS, 32, number of architectural registers; index width is 5 bits.
- RESET_PC4, 32'd0, value loaded into id_ex_pc4 on reset.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- if_id  input  64  [63:32] PC+4, [31:0] instruction (fetch output format)
- flush  input  1  branch taken in MEM; squash the instruction now in ID
- wb_reg_write  input  1  write-back register write enable
- wb_write_reg  input  5  write-back destination register
- wb_write_data  input  32  write-back data
- stall  output  1  combinational; high means fetch holds PC and IF/ID
- id_ex_wb  output  2  [1] RegWrite, [0] MemtoReg
- id_ex_m  output  3  [2] Branch, [1] MemRead, [0] MemWrite
- id_ex_ex  output  4  [3:2] ALUOp, [1] RegDst, [0] ALUSrc
- id_ex_pc4  output  32  registered PC+4
- id_ex_rd1  output  32  registered rs data
- id_ex_rd2  output  32  registered rt data
- id_ex_imm  output  32  sign-extended instr[15:0]
- id_ex_rs, id_ex_rt, id_ex_rd  output  5 each  register indices for forwarding and the RegDst mux

Behaviour:
- Reset (async, active-high):
  - All id_ex_* outputs go to 0, except id_ex_pc4, which goes to RESET_PC4.
  - All registers in the register file go to 0.
  - stall is 0 while reset is asserted.
- Field decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Control truth table (bit order WB/M/EX as given in Ports):
  - R-type, op 0x00: WB=10, M=000, EX=1010
  - lw, op 0x23: WB=11, M=010, EX=0001
  - sw, op 0x2B: WB=00, M=001, EX=0001
  - beq, op 0x04: WB=00, M=100, EX=0100
  - addi, op 0x08: WB=10, M=000, EX=0001
  - Any other opcode: all control bits 0 (NOP).
- Register file:
  - Writes at posedge clk when wb_reg_write=1 and wb_write_reg!=0.
  - Register 0 always reads 0 and is never written.
  - Reads are combinational.
  - Same-cycle bypass: if wb_reg_write, wb_write_reg!=0 and wb_write_reg equals rs (or rt), the read returns wb_write_data. ID therefore sees a value written back in the same cycle.
- Sign extension: imm[15] replicated into bits [31:16]; no zero-extend mode.
- Hazard detection:
  - stall = id_ex_m[1] & (id_ex_rt!=0) & ((id_ex_rt==rs) | (id_ex_rt==rt)).
  - rt is compared for every opcode; a conservative extra stall is accepted.
- ID/EX register update, at each posedge clk, in this priority order:
  1. reset: reset values.
  2. flush=1: bubble. Control fields go to 0; data and index fields load normally (don't-care).
  3. stall=1: bubble, same as flush. The IF/ID hold is upstream's job; this stage simply re-decodes next cycle.
  4. Otherwise: load the decoded control, pc4, rd1, rd2, imm, rs, rt, rd.
- Latency: one cycle from IF/ID to ID/EX. A load-use dependency costs exactly one bubble, because stall deasserts once the bubble (MemRead=0) occupies ID/EX.
- Simultaneous flush and stall: flush wins. The result is still a bubble, and stall remains asserted that cycle.
- A write-back to a register in the same cycle as a stall takes effect normally.
- Reset asserted mid-operation: outputs clear immediately and asynchronously, without waiting for a clock edge.

Decomposition:
- Shared header mips_defs.vh holds:
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI.
  - ALUOp encodings: 00 add, 01 sub, 10 funct.
  - Bit positions of the WB/M/EX fields, for reuse by execute, memory and write-back.
- One sub-module, id_register_file: 32x32 storage, async reset, two read ports, one write port, bypass logic.
- Control decode and hazard detection stay inline.

Test Plan:
- Reset, then release: all id_ex_* = 0 and stall=0. Write 0xDEADBEEF to r0 via WB, then decode an instruction reading rs=0 -> id_ex_rd1=0.
- Write r5=0x00000007 in a prior cycle. Present addi r6,r5,-4 (0x20A6FFFC) with pc4=0x44 -> next cycle: id_ex_wb=10, id_ex_ex=0001, id_ex_rd1=7, id_ex_imm=0xFFFFFFFC, id_ex_pc4=0x44, id_ex_rt=6.
- Same-cycle bypass: WB writes r9=0x12345678 while add r10,r9,r9 (0x012950 20) is in ID -> id_ex_rd1=id_ex_rd2=0x12345678 and id_ex_rd=10.
- Load-use: lw r2,0(r1) followed by add r3,r2,r4 -> stall=1 for exactly one cycle, a bubble appears (id_ex_m=000, id_ex_wb=00), and the add enters ID/EX on the following cycle.
- flush=1 while beq (0x10220003) is in ID -> id_ex control all 0. Unknown opcode 0x3F -> control all 0 with no stall.
- Assert reset mid-stream with a lw in ID/EX -> outputs clear without a clock edge, stall drops to 0, and all registers read 0 afterwards.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared MIPS decode definitions: opcodes, ALUOp codes and
// control-field bit positions reused by the later pipeline stages.
package id_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  localparam int EX_ALUOP_HI = 3;
  localparam int EX_ALUOP_LO = 2;
  localparam int EX_REGDST   = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [2:0] m;
    logic [3:0] ex;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      (op == OP_RTYPE): c = '{2'b10, 3'b000, {ALUOP_FUNCT, 2'b10}};
      (op == OP_LW):    c = '{2'b11, 3'b010, {ALUOP_ADD, 2'b01}};
      (op == OP_SW):    c = '{2'b00, 3'b001, {ALUOP_ADD, 2'b01}};
      (op == OP_BEQ):   c = '{2'b00, 3'b100, {ALUOP_SUB, 2'b00}};
      (op == OP_ADDI):  c = '{2'b10, 3'b000, {ALUOP_ADD, 2'b01}};
      default:          c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_register_file.sv
// 32x32 register file, two combinational read ports, one write port,
// with same-cycle write-back bypass and r0 hard-wired to zero.
module id_register_file #(
  parameter int NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [NUM_REGS];
  logic        w_wen;

  assign w_wen = i_we & (i_waddr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_wen) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Bypass lets ID see the value being written back this cycle.
  always_comb begin
    o_rdata1 = r_regs[i_raddr1];
    if (i_raddr1 == 5'd0)
      o_rdata1 = '0;
    else if (w_wen && i_waddr == i_raddr1)
      o_rdata1 = i_wdata;
  end

  always_comb begin
    o_rdata2 = r_regs[i_raddr2];
    if (i_raddr2 == 5'd0)
      o_rdata2 = '0;
    else if (w_wen && i_waddr == i_raddr2)
      o_rdata2 = i_wdata;
  end

endmodule

// File: rtl/id_stage.sv
// MIPS instruction-decode stage: register file, control decode,
// sign extension, load-use stall and the ID/EX pipeline register.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] RESET_PC4 = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] if_id,
  input  logic        flush,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_write_reg,
  input  logic [31:0] wb_write_data,
  output logic        stall,
  output logic [1:0]  id_ex_wb,
  output logic [2:0]  id_ex_m,
  output logic [3:0]  id_ex_ex,
  output logic [31:0] id_ex_pc4,
  output logic [31:0] id_ex_rd1,
  output logic [31:0] id_ex_rd2,
  output logic [31:0] id_ex_imm,
  output logic [4:0]  id_ex_rs,
  output logic [4:0]  id_ex_rt,
  output logic [4:0]  id_ex_rd
);

  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm16;
  logic [31:0] w_imm;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  ctrl_t       w_ctrl;
  logic        w_bubble;

  assign w_pc4   = if_id[63:32];
  assign w_instr = if_id[31:0];
  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_imm16 = w_instr[15:0];
  assign w_imm   = {{16{w_imm16[15]}}, w_imm16};
  assign w_ctrl  = decode_ctrl(w_op);

  id_register_file #(
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .i_raddr1 (w_rs),
    .i_raddr2 (w_rt),
    .o_rdata1 (w_rd1),
    .o_rdata2 (w_rd2),
    .i_we     (wb_reg_write),
    .i_waddr  (wb_write_reg),
    .i_wdata  (wb_write_data)
  );

  // rt is compared for every opcode; an occasional extra stall is fine.
  assign stall = id_ex_m[M_MEMREAD] & (id_ex_rt != 5'd0) &
                 ((id_ex_rt == w_rs) | (id_ex_rt == w_rt));

  assign w_bubble = flush | stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_ex_wb  <= '0;
      id_ex_m   <= '0;
      id_ex_ex  <= '0;
      id_ex_pc4 <= RESET_PC4;
      id_ex_rd1 <= '0;
      id_ex_rd2 <= '0;
      id_ex_imm <= '0;
      id_ex_rs  <= '0;
      id_ex_rt  <= '0;
      id_ex_rd  <= '0;
    end else begin
      if (w_bubble) begin
        id_ex_wb <= '0;
        id_ex_m  <= '0;
        id_ex_ex <= '0;
      end else begin
        id_ex_wb <= w_ctrl.wb;
        id_ex_m  <= w_ctrl.m;
        id_ex_ex <= w_ctrl.ex;
      end
      id_ex_pc4 <= w_pc4;
      id_ex_rd1 <= w_rd1;
      id_ex_rd2 <= w_rd2;
      id_ex_imm <= w_imm;
      id_ex_rs  <= w_rs;
      id_ex_rt  <= w_rt;
      id_ex_rd  <= w_rd;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: an independent model predicts each
// ID/EX word and the stall flag; the DUT is checked after each edge.
module tb_id_stage;

  localparam logic [31:0] RST_PC4 = 32'd0;

  typedef struct packed {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [3:0]  ex;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] if_id;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        stall;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_pc4;
  logic [31:0] id_ex_rd1;
  logic [31:0] id_ex_rd2;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] m_regs [32];
  exp_t        sb [$];
  exp_t        cur;
  exp_t        rst_e;

  id_stage #(
    .NUM_REGS  (32),
    .RESET_PC4 (RST_PC4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_id         (if_id),
    .flush         (flush),
    .wb_reg_write  (wb_reg_write),
    .wb_write_reg  (wb_write_reg),
    .wb_write_data (wb_write_data),
    .stall         (stall),
    .id_ex_wb      (id_ex_wb),
    .id_ex_m       (id_ex_m),
    .id_ex_ex      (id_ex_ex),
    .id_ex_pc4     (id_ex_pc4),
    .id_ex_rd1     (id_ex_rd1),
    .id_ex_rd2     (id_ex_rd2),
    .id_ex_imm     (id_ex_imm),
    .id_ex_rs      (id_ex_rs),
    .id_ex_rt      (id_ex_rt),
    .id_ex_rd      (id_ex_rd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic exp_t obs();
    return {id_ex_wb, id_ex_m, id_ex_ex, id_ex_pc4, id_ex_rd1,
            id_ex_rd2, id_ex_imm, id_ex_rs, id_ex_rt, id_ex_rd};
  endfunction

  function automatic logic [8:0] mctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'b10_000_1010;
      6'h23:   return 9'b11_010_0001;
      6'h2B:   return 9'b00_001_0001;
      6'h04:   return 9'b00_100_0100;
      6'h08:   return 9'b10_000_0001;
      default: return 9'b0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_reg_write && wb_write_reg == a) return wb_write_data;
    return m_regs[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    if (wb_reg_write && wb_write_reg != 5'd0)
      m_regs[wb_write_reg] = wb_write_data;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    sb.delete();
    cur = rst_e;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a,
                        input logic [31:0] d);
    wb_reg_write = we;
    wb_write_reg = a;
    wb_write_data = d;
  endtask

  // Present an IF/ID word and push the predicted ID/EX result.
  task automatic drive(input logic [63:0] v, input logic fl,
                       output logic st);
    exp_t e;
    logic [31:0] ins;
    if_id = v;
    flush = fl;
    ins = v[31:0];
    st = cur.m[1] && cur.rt != 5'd0 &&
         (cur.rt == ins[25:21] || cur.rt == ins[20:16]);
    {e.wb, e.m, e.ex} = (fl || st) ? 9'd0 : mctrl(ins[31:26]);
    e.pc4 = v[63:32];
    e.rd1 = mread(ins[25:21]);
    e.rd2 = mread(ins[20:16]);
    e.imm = {{16{ins[15]}}, ins[15:0]};
    e.rs = ins[25:21];
    e.rt = ins[20:16];
    e.rd = ins[15:11];
    sb.push_back(e);
    cur = e;
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic st;
    reset = 1'b1;
    if_id = '0;
    flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'd0);
    #3;
    n_chk++;
    if (obs() !== rst_e || stall !== 1'b0)
      $display("FAIL reset_state got=%h stall=%b want=%h stall=0",
               obs(), stall, rst_e);
    else n_pass++;
    tick();
    reset = 1'b0;
    clear_model();
    set_wb(1'b1, 5'd0, 32'hDEADBEEF);
    drive({32'h4, 32'h00001020}, 1'b0, st);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_rd1 !== 32'd0)
      $display("FAIL r0_bypass got=%h want=%h", obs(), e);
    else n_pass++;
    set_wb(1'b0, 5'd0, 32'd0);
    drive({32'h8, 32'h00001020}, 1'b0, st);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_rd1 !== 32'd0)
      $display("FAIL r0_read got=%h want=%h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_addi();
    exp_t e;
    logic st;
    set_wb(1'b1, 5'd5, 32'h7);
    drive({32'h40, 32'h0}, 1'b0, st);
    tick();
    e = sb.pop_front();
    set_wb(1'b0, 5'd0, 32'd0);
    drive({32'h44, 32'h20A6FFFC}, 1'b0, st);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_wb !== 2'b10 || id_ex_ex !== 4'b0001 ||
        id_ex_rd1 !== 32'h7 || id_ex_imm !== 32'hFFFFFFFC ||
        id_ex_pc4 !== 32'h44 || id_ex_rt !== 5'd6)
      $display("FAIL addi got=%h want=%h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_bypass();
    exp_t e;
    logic st;
    set_wb(1'b1, 5'd9, 32'h12345678);
    drive({32'h48, 32'h01295020}, 1'b0, st);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_rd1 !== 32'h12345678 ||
        id_ex_rd2 !== 32'h12345678 || id_ex_rd !== 5'd10)
      $display("FAIL bypass got=%h want=%h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_load_use();
    exp_t e;
    logic st;
    set_wb(1'b1, 5'd4, 32'h55);
    drive({32'h50, 32'h8C220000}, 1'b0, st);
    n_chk++;
    if (stall !== 1'b0) $display("FAIL lu_lw_stall got=%b want=0", stall);
    else n_pass++;
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_m !== 3'b010)
      $display("FAIL lu_lw got=%h want=%h", obs(), e);
    else n_pass++;
    drive({32'h54, 32'h00441820}, 1'b0, st);
    n_chk++;
    if (stall !== 1'b1 || st !== 1'b1)
      $display("FAIL lu_stall got=%b want=1", stall);
    else n_pass++;
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_m !== 3'b000 || id_ex_wb !== 2'b00)
      $display("FAIL lu_bubble got=%h want=%h", obs(), e);
    else n_pass++;
    drive({32'h54, 32'h00441820}, 1'b0, st);
    n_chk++;
    if (stall !== 1'b0) $display("FAIL lu_release got=%b want=0", stall);
    else n_pass++;
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || id_ex_wb !== 2'b10 || id_ex_rd !== 5'd3)
      $display("FAIL lu_add got=%h want=%h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_flush();
    exp_t e;
    logic st;
    drive({32'h60, 32'h10220003}, 1'b1, st);
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || {id_ex_wb, id_ex_m, id_ex_ex} !== 9'd0)
      $display("FAIL flush_beq got=%h want=%h", obs(), e);
    else n_pass++;
    drive({32'h64, 32'h8C220000}, 1'b0, st);
    tick();
    e = sb.pop_front();
    drive({32'h68, 32'h00441820}, 1'b1, st);
    n_chk++;
    if (stall !== 1'b1) $display("FAIL flush_stall got=%b want=1", stall);
    else n_pass++;
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || {id_ex_wb, id_ex_m, id_ex_ex} !== 9'd0)
      $display("FAIL flush_and_stall got=%h want=%h", obs(), e);
    else n_pass++;
    drive({32'h6C, 32'hFC430000}, 1'b0, st);
    n_chk++;
    if (stall !== 1'b0) $display("FAIL unk_stall got=%b want=0", stall);
    else n_pass++;
    tick();
    e = sb.pop_front();
    n_chk++;
    if (obs() !== e || {id_ex_wb, id_ex_m, id_ex_ex} !== 9'd0)
      $display("FAIL unknown_op got=%h want=%h", obs(), e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic st;
    logic [5:0] ops [6];
    logic [31:0] ins;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h3F};
    st = 1'b0;
    ins = 32'h0;
    for (int i = 0; i < 60; i++) begin
      if (!st)
        ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 16'($urandom)};
      set_wb(1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      drive({32'h100 + 32'(i * 4), ins}, ($urandom_range(0, 7) == 0), st);
      n_chk++;
      if (stall !== st) $display("FAIL b2b_stall[%0d] got=%b want=%b", i, stall, st);
      else n_pass++;
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e) $display("FAIL b2b[%0d] got=%h want=%h", i, obs(), e);
      else n_pass++;
    end
    set_wb(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_async_reset();
    exp_t e;
    logic st;
    set_wb(1'b1, 5'd1, 32'hABCD);
    drive({32'h200, 32'h8C220000}, 1'b0, st);
    tick();
    set_wb(1'b0, 5'd0, 32'd0);
    e = sb.pop_front();
    drive({32'h204, 32'h00441820}, 1'b0, st);
    n_chk++;
    if (stall !== 1'b1) $display("FAIL ar_pre_stall got=%b want=1", stall);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if (obs() !== rst_e || stall !== 1'b0)
      $display("FAIL async_reset got=%h stall=%b want=%h", obs(), stall, rst_e);
    else n_pass++;
    tick();
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 16; i++) begin
      drive({32'h300, 6'h0, 5'(2 * i), 5'(2 * i + 1), 16'h0}, 1'b0, st);
      tick();
      e = sb.pop_front();
      n_chk++;
      if (obs() !== e || id_ex_rd1 !== 32'd0 || id_ex_rd2 !== 32'd0)
        $display("FAIL ar_regs[%0d] got=%h want=%h", i, obs(), e);
      else n_pass++;
    end
  endtask

  initial begin
    rst_e = '0;
    rst_e.pc4 = RST_PC4;
    cur = rst_e;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
